// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if -- bundle of every handshake and bus signal around the
// shift_arbiter: two requester command channels, the shifter control/data
// bus, the response channel and the busy flag.
//
//   req0_* / req1_*  : requester command channels (valid/ready, op, amt, data)
//   sh_c, sh_s, sh_i : shifter control code, shift amount, load data
//   sh_o             : shifter register output
//   rsp_*            : response channel (valid/ready, id, data)
//   busy             : arbiter is not idle
//
// Modports:
//   slave  -- the arbiter itself
//   master -- the environment (requesters, shifter, response consumer)
interface shift_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [2:0] req0_amt;
  logic [7:0] req0_data;

  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [2:0] req1_amt;
  logic [7:0] req1_data;

  logic [1:0] sh_c;
  logic [2:0] sh_s;
  logic [7:0] sh_i;
  logic [7:0] sh_o;

  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_ready;

  logic       busy;

  modport slave (
    input  req0_valid, req0_op, req0_amt, req0_data,
    input  req1_valid, req1_op, req1_amt, req1_data,
    output req0_ready, req1_ready,
    output sh_c, sh_s, sh_i,
    input  sh_o,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_amt, req0_data,
    output req1_valid, req1_op, req1_amt, req1_data,
    input  req0_ready, req1_ready,
    input  sh_c, sh_s, sh_i,
    output sh_o,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter -- round-robin arbiter that lets two requesters share one
// external 8-bit shift register. A granted command is issued to the shifter
// for exactly one cycle, the block then waits LAT cycles for the shifter
// output to settle, captures it and holds it on the response channel until
// the consumer takes it.
//
// Parameters:
//   LAT   : cycles from the shifter control edge to a valid sh_o (1..15)
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_arbiter_if.slave (requesters, shifter bus, response, busy)
module shift_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [1:0] state;
  logic       last;       // index of the most recent winner
  logic [3:0] wait_cnt;   // remaining WAIT cycles

  // Command latched on the accepting edge.
  logic [1:0] op_q;
  logic [2:0] amt_q;
  logic [7:0] data_q;
  logic       id_q;

  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [7:0] rsp_data_q;

  logic grant0;
  logic grant1;
  logic ready0;
  logic ready1;
  logic accept;

  // Round-robin: a lone requester always wins; under contention the one
  // that did not win last time goes first.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last;
      grant1 = !last;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Ready is combinational from valid, so it is also gated by rst_n to keep
  // both readies low while reset is held even though the state reads IDLE.
  assign ready0 = rst_n && (state == ST_IDLE) && bus.req0_valid && grant0;
  assign ready1 = rst_n && (state == ST_IDLE) && bus.req1_valid && grant1;
  assign accept = ready0 || ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;

  // Shifter bus: a command only during the single ISSUE cycle, otherwise the
  // hold code with zero amount/data. Fields that are meaningless for the op
  // are forced to zero rather than passed through.
  always_comb begin
    bus.sh_c = OP_HOLD;
    bus.sh_s = 3'd0;
    bus.sh_i = 8'h00;
    if (state == ST_ISSUE) begin
      bus.sh_c = op_q;
      if (op_q == OP_SHL || op_q == OP_SHR) bus.sh_s = amt_q;
      if (op_q == OP_LOAD)                  bus.sh_i = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      wait_cnt    <= 4'd0;
      op_q        <= OP_HOLD;
      amt_q       <= 3'd0;
      data_q      <= 8'h00;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= ready1 ? bus.req1_op   : bus.req0_op;
            amt_q  <= ready1 ? bus.req1_amt  : bus.req0_amt;
            data_q <= ready1 ? bus.req1_data : bus.req0_data;
            id_q   <= ready1;
            last   <= ready1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= LAT_CNT;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Counter holds the cycles still to go including the current one,
          // so the edge seen with a count of 1 ends the last WAIT cycle.
          if (wait_cnt <= 4'd1) begin
            wait_cnt    <= 4'd0;
            rsp_data_q  <= bus.sh_o;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter -- self-checking bench for shift_arbiter with LAT = 1.
// An 8-bit shift register model sits on the shifter bus; expected results
// come from a plain arithmetic model of the commands kept in ref_val.
module tb_shift_arbiter;

  localparam int LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter #(.LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shifter: one register stage, which is a valid sh_o one cycle after the
  // control edge (LAT = 1). Not reset by rst_n.
  logic [7:0] sh_reg = 8'h00;
  always @(posedge clk) begin
    case (bus.sh_c)
      2'b01:   sh_reg <= sh_reg << bus.sh_s;
      2'b10:   sh_reg <= sh_reg >> bus.sh_s;
      2'b11:   sh_reg <= bus.sh_i;
      default: sh_reg <= sh_reg;
    endcase
  end
  assign bus.sh_o = sh_reg;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] ref_val = 8'h00;

  typedef struct {
    bit         acc;      // command accepted within budget
    logic [1:0] c;        // sh_c seen in the cycle after accept
    logic [2:0] s;
    logic [7:0] i;
    int         lat;      // edges after the accepting edge until rsp_valid
    logic       rid;
    logic [7:0] rdata;
    bit         stable;   // rsp fields unchanged under back-pressure
    bit         busy_ok;  // busy high in every sampled non-idle cycle
    bit         leak;     // a req_ready seen while not idle
    bit         cleared;  // rsp_valid low after the rsp_ready edge
  } obs_t;

  function automatic logic [7:0] apply(input logic [7:0] v, input logic [1:0] op,
                                       input logic [2:0] amt, input logic [7:0] d);
    case (op)
      2'b01:   return v << amt;
      2'b10:   return v >> amt;
      2'b11:   return d;
      default: return v;
    endcase
  endfunction

  function automatic logic [25:0] outs();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy, bus.req0_ready,
            bus.req1_ready, bus.sh_c, bus.sh_s, bus.sh_i};
  endfunction

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_amt = 3'd0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_amt = 3'd0; bus.req1_data = 8'h00;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic poke_valids(input bit hold);
    bus.req0_valid = hold ? 1'b1 : 1'($urandom);
    bus.req1_valid = hold ? 1'b1 : 1'($urandom);
  endtask

  // Runs one command from requester id, entered and left just after a
  // falling edge. While busy, the request valids are poked (randomly or
  // held high) and rsp_ready is randomized until the response shows up; both
  // must be ignored. The response is then held for bp cycles before release.
  task automatic run_cmd(input bit id, input logic [1:0] op, input logic [2:0] amt,
                         input logic [7:0] data, input int bp, input bit hold, output obs_t o);
    o = '{acc: 1'b0, c: 2'bx, s: 3'bx, i: 8'bx, lat: -1, rid: 1'bx, rdata: 8'bx,
          stable: 1'b1, busy_ok: 1'b1, leak: 1'b0, cleared: 1'b0};
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (id) begin
      bus.req1_op = op; bus.req1_amt = amt; bus.req1_data = data; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_amt = amt; bus.req0_data = data; bus.req0_valid = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        o.acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!o.acc) begin
      clear_inputs();
      return;
    end
    @(posedge clk);                     // accepting edge
    @(negedge clk);                     // ISSUE cycle
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    o.c = bus.sh_c; o.s = bus.sh_s; o.i = bus.sh_i;
    if (bus.busy !== 1'b1) o.busy_ok = 1'b0;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) o.leak = 1'b1;
    poke_valids(hold);
    for (int n = 1; n <= 40; n++) begin
      bus.rsp_ready = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) o.leak = 1'b1;
      if (bus.busy !== 1'b1) o.busy_ok = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        o.lat = n;
        break;
      end
      poke_valids(hold);
    end
    if (o.lat < 0) begin
      clear_inputs();
      return;
    end
    o.rid   = bus.rsp_id;
    o.rdata = bus.rsp_data;
    bus.rsp_ready = 1'b0;
    repeat (bp) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== o.rid || bus.rsp_data !== o.rdata)
        o.stable = 1'b0;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) o.leak = 1'b1;
      if (bus.busy !== 1'b1) o.busy_ok = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    o.cleared = (bus.rsp_valid === 1'b0) && (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (outs() !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", outs());
    end
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (outs() !== 26'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, expected 0", outs());
    end
  endtask

  task automatic test_directed();
    obs_t o;
    // Load: amt must not reach the shifter for op 11.
    run_cmd(1'b0, 2'b11, 3'd5, 8'h96, 0, 1'b0, o);
    ref_val = apply(ref_val, 2'b11, 3'd5, 8'h96);
    n_tests++;
    if (!o.acc || o.c !== 2'b11 || o.s !== 3'd0 || o.i !== 8'h96) begin
      n_fail++;
      $display("FAIL load_ctrl: got acc=%0d c=%b s=%0d i=%h, expected acc=1 c=11 s=0 i=96",
               o.acc, o.c, o.s, o.i);
    end
    // Counting the accepting edge itself, rsp_valid rises on edge LAT+2.
    n_tests++;
    if (o.lat !== LAT + 1) begin
      n_fail++;
      $display("FAIL load_latency: got %0d edges, expected %0d", o.lat, LAT + 1);
    end
    n_tests++;
    if (o.rid !== 1'b0 || o.rdata !== 8'h96 || !o.cleared) begin
      n_fail++;
      $display("FAIL load_rsp: got id=%b data=%h cleared=%0d, expected id=0 data=96 cleared=1",
               o.rid, o.rdata, o.cleared);
    end
    // Shift left: data must not reach the shifter for op 01.
    run_cmd(1'b1, 2'b01, 3'd3, 8'h5A, 0, 1'b0, o);
    ref_val = apply(ref_val, 2'b01, 3'd3, 8'h5A);
    n_tests++;
    if (!o.acc || o.c !== 2'b01 || o.s !== 3'd3 || o.i !== 8'h00) begin
      n_fail++;
      $display("FAIL shl_ctrl: got acc=%0d c=%b s=%0d i=%h, expected acc=1 c=01 s=3 i=00",
               o.acc, o.c, o.s, o.i);
    end
    n_tests++;
    if (o.rid !== 1'b1 || o.rdata !== 8'hB0) begin
      n_fail++;
      $display("FAIL shl_rsp: got id=%b data=%h, expected id=1 data=b0", o.rid, o.rdata);
    end
    run_cmd(1'b0, 2'b10, 3'd5, 8'hFF, 0, 1'b0, o);
    ref_val = apply(ref_val, 2'b10, 3'd5, 8'hFF);
    n_tests++;
    if (o.rid !== 1'b0 || o.rdata !== 8'h05 || o.s !== 3'd5 || o.i !== 8'h00) begin
      n_fail++;
      $display("FAIL shr_rsp: got id=%b data=%h s=%0d i=%h, expected id=0 data=05 s=5 i=00",
               o.rid, o.rdata, o.s, o.i);
    end
  endtask

  task automatic test_backpressure();
    obs_t       o;
    logic [7:0] exp;
    exp = apply(ref_val, 2'b01, 3'd1, 8'h00);
    run_cmd(1'b1, 2'b01, 3'd1, 8'h00, 5, 1'b1, o);
    ref_val = exp;
    n_tests++;
    if (!o.stable || o.leak || !o.busy_ok) begin
      n_fail++;
      $display("FAIL backpressure: got stable=%0d leak=%0d busy_ok=%0d, expected 1 0 1",
               o.stable, o.leak, o.busy_ok);
    end
    n_tests++;
    if (o.rdata !== exp || o.rid !== 1'b1 || !o.cleared) begin
      n_fail++;
      $display("FAIL backpressure_rsp: got id=%b data=%h cleared=%0d, expected id=1 data=%h cleared=1",
               o.rid, o.rdata, o.cleared, exp);
    end
  endtask

  task automatic test_drop();
    // A valid that is withdrawn before any rising edge records nothing.
    bus.req1_op = 2'b11; bus.req1_data = 8'hEE; bus.req1_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_ready_up: got %b, expected 1", bus.req1_ready);
    end
    #2;
    bus.req1_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ready_down: got %b, expected 0", bus.req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.sh_c !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_no_cmd: got busy=%b sh_c=%b, expected busy=0 sh_c=00", bus.busy, bus.sh_c);
    end
  endtask

  task automatic test_random();
    obs_t       o;
    bit         id;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
    int         bp;
    for (int t = 0; t < 24; t++) begin
      id   = 1'($urandom);
      op   = 2'($urandom);
      amt  = 3'($urandom);
      data = 8'($urandom);
      bp   = $urandom_range(0, 4);
      exp  = apply(ref_val, op, amt, data);
      run_cmd(id, op, amt, data, bp, 1'b0, o);
      ref_val = exp;
      n_tests++;
      if (!o.acc || o.c !== op || o.s !== ((op == 2'b01 || op == 2'b10) ? amt : 3'd0) ||
          o.i !== ((op == 2'b11) ? data : 8'h00)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got acc=%0d c=%b s=%0d i=%h, op=%b amt=%0d data=%h",
                 t, o.acc, o.c, o.s, o.i, op, amt, data);
      end
      n_tests++;
      if (o.lat !== LAT + 1 || o.rid !== id || o.rdata !== exp) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got lat=%0d id=%b data=%h, expected lat=%0d id=%b data=%h",
                 t, o.lat, o.rid, o.rdata, LAT + 1, id, exp);
      end
      n_tests++;
      if (!o.stable || o.leak || !o.busy_ok || !o.cleared) begin
        n_fail++;
        $display("FAIL rand_hs[%0d]: got stable=%0d leak=%0d busy_ok=%0d cleared=%0d, expected 1 0 1 1",
                 t, o.stable, o.leak, o.busy_ok, o.cleared);
      end
    end
  endtask

  task automatic test_abort();
    obs_t       o;
    logic [2:0] amt;
    logic [7:0] data;
    bit         seen;
    amt = 3'($urandom_range(1, 7));
    bus.req0_op = 2'b01; bus.req0_amt = amt; bus.req0_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_accept: got ready=%b, expected 1", bus.req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(posedge clk);                     // ISSUE ends, shifter takes the command
    ref_val = apply(ref_val, 2'b01, amt, 8'h00);
    @(negedge clk);                     // WAIT
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (outs() !== 26'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h, expected 0", outs());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_rsp: got activity after abort, expected none");
    end
    data = 8'($urandom);
    run_cmd(1'b1, 2'b11, 3'd2, data, 1, 1'b0, o);
    ref_val = data;
    n_tests++;
    if (o.lat !== LAT + 1 || o.rid !== 1'b1 || o.rdata !== data || !o.cleared) begin
      n_fail++;
      $display("FAIL abort_recover: got lat=%0d id=%b data=%h cleared=%0d, expected lat=%0d id=1 data=%h cleared=1",
               o.lat, o.rid, o.rdata, o.cleared, LAT + 1, data);
    end
  endtask

  task automatic test_contention();
    int         grants[$];
    int         gcyc[$];
    logic [8:0] expq[$];
    logic [8:0] e;
    int         seen;
    bit         stop_req;
    bit         gid;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_op = 2'b01; bus.req0_amt = 3'($urandom); bus.req0_data = 8'($urandom);
    bus.req1_op = 2'b11; bus.req1_amt = 3'($urandom); bus.req1_data = 8'($urandom);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    seen     = 0;
    stop_req = 1'b0;
    for (int k = 0; k < 100 && seen < 4; k++) begin
      if (stop_req) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (bus.rsp_valid === 1'b1) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL cont_rsp: got unexpected response id=%b data=%h", bus.rsp_id, bus.rsp_data);
        end else begin
          e = expq.pop_front();
          if ({bus.rsp_id, bus.rsp_data} !== e) begin
            n_fail++;
            $display("FAIL cont_rsp: got id=%b data=%h, expected id=%b data=%h",
                     bus.rsp_id, bus.rsp_data, e[8], e[7:0]);
          end
        end
        seen++;
      end
      if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL cont_one_ready: got both readies high, expected at most one");
      end else if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        gid = bus.req1_ready;
        grants.push_back(int'(gid));
        gcyc.push_back(k);
        ref_val = gid ? apply(ref_val, bus.req1_op, bus.req1_amt, bus.req1_data)
                      : apply(ref_val, bus.req0_op, bus.req0_amt, bus.req0_data);
        expq.push_back({gid, ref_val});
        if (grants.size() == 4) stop_req = 1'b1;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (seen != 4 || grants.size() != 4) begin
      n_fail++;
      $display("FAIL cont_count: got %0d grants %0d responses, expected 4 4", grants.size(), seen);
    end else begin
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if (grants[g] != (g % 2)) begin
          n_fail++;
          $display("FAIL cont_order[%0d]: got grant %0d, expected %0d", g, grants[g], g % 2);
        end
      end
      for (int g = 1; g < 4; g++) begin
        n_tests++;
        if (gcyc[g] - gcyc[g-1] < LAT + 3) begin
          n_fail++;
          $display("FAIL cont_gap[%0d]: got %0d cycles, expected at least %0d",
                   g, gcyc[g] - gcyc[g-1], LAT + 3);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    test_directed();
    test_backpressure();
    test_drop();
    test_random();
    test_abort();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
